inst_fetch: RTL and testbench

- Sequential instruction-fetch front end. It owns the fetch PC register and issues in-order requests to instruction memory.
- It buffers returned instructions and hands them to decode over a valid/ready interface.
- It is the consumer of the next-PC selection. When a jump or taken branch resolves, the selected target arrives on the redirect port, and this block flushes wrong-path work.
- Up to DEPTH requests/instructions are in flight or buffered at once.

---
 rtl/inst_fetch_if.sv | 33 +++
 rtl/inst_fetch.sv | 122 ++++++++++++
 tb/tb_inst_fetch.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: redirect input, instruction-memory request/response,
// and the decode-side valid/ready handoff plus the fetch PC trace output.
// master = fetch unit side, slave = surrounding pipeline / memory side.
interface inst_fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] fetch_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_ready,
        output imem_req_valid, imem_req_addr,
        output if_valid, if_pc, if_inst, fetch_pc
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_ready,
        input  imem_req_valid, imem_req_addr,
        input  if_valid, if_pc, if_inst, fetch_pc
    );
endinterface

// File: rtl/inst_fetch.sv
// Sequential fetch front end: owns the fetch PC, issues in-order imem requests.
// Latency: response in cycle N is presented to decode in cycle N+1.
// Backpressure: credit-limited to DEPTH requests+buffered instrs; no comb path if_ready->req.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    // Fetch PC and in-order tag queue of issued-but-unanswered request addresses
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   tag_mem_q [DEPTH];
    logic [PW-1:0] tag_wr_q, tag_rd_q;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;

    // Instruction buffer holding {pc, inst} pairs for decode
    logic [31:0]   buf_pc_q   [DEPTH];
    logic [31:0]   buf_inst_q [DEPTH];
    logic [PW-1:0] buf_wr_q, buf_rd_q;
    logic [CW-1:0] buf_cnt_q, buf_cnt_d;
    logic          if_valid_q;

    logic [CW:0]   credits;
    logic          req_fire;
    logic          resp;
    logic          resp_keep;
    logic          pop;
    logic          redirect;

    assign redirect  = bus.redirect_valid;
    assign credits   = {1'b0, out_q} + {1'b0, buf_cnt_q};
    assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    assign resp      = bus.imem_resp_valid;
    // Responses are dropped while wrong-path work drains, and during a redirect cycle
    assign resp_keep = resp && (disc_q == '0) && !redirect;
    // A pop during redirect is moot: the whole buffer is cleared anyway
    assign pop       = if_valid_q && bus.if_ready && !redirect;

    assign bus.imem_req_valid = (credits < DEPTH_C) && !redirect && !rst;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.fetch_pc       = fetch_pc_q;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_pc          = if_valid_q ? buf_pc_q[buf_rd_q]   : 32'h0;
    assign bus.if_inst        = if_valid_q ? buf_inst_q[buf_rd_q] : 32'h0;

    // Next-state for PC, outstanding count, discard count and buffer occupancy
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q + CW'(req_fire) - CW'(resp);
        disc_d     = disc_q;
        buf_cnt_d  = buf_cnt_q + CW'(resp_keep) - CW'(pop);
        if (redirect) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            // Everything still in flight after this cycle's retire is wrong-path
            disc_d     = out_q - CW'(resp);
            buf_cnt_d  = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp && (disc_q != '0)) begin
                disc_d = disc_q - CW'(1'b1);
            end
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            out_q      <= '0;
            disc_q     <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
            buf_cnt_q  <= '0;
            if_valid_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            buf_cnt_q  <= buf_cnt_d;
            if_valid_q <= (buf_cnt_d != '0);
            if (req_fire) begin
                tag_wr_q <= tag_wr_q + PW'(1'b1);
            end
            if (resp) begin
                tag_rd_q <= tag_rd_q + PW'(1'b1);
            end
            if (redirect) begin
                buf_wr_q <= '0;
                buf_rd_q <= '0;
            end else begin
                if (resp_keep) begin
                    buf_wr_q <= buf_wr_q + PW'(1'b1);
                end
                if (pop) begin
                    buf_rd_q <= buf_rd_q + PW'(1'b1);
                end
            end
        end
    end

    // Data storage for tags and buffered instructions; validity tracked by pointers
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem_q[tag_wr_q] <= fetch_pc_q;
        end
        if (resp_keep) begin
            buf_pc_q[buf_wr_q]   <= tag_mem_q[tag_rd_q];
            buf_inst_q[buf_wr_q] <= bus.imem_resp_data;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with an in-order memory model and a {pc,inst} scoreboard.
module tb_inst_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] deliv_q[$];
    logic [31:0] hs_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic [31:0] model_pc;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge
    task automatic step();
        logic [63:0] e;
        if (!rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = data_of(pend_q[0].addr);
            void'(pend_q.pop_front());
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end
        #1;
        if (bus.redirect_valid) begin
            check("redir_noreq", {31'h0, bus.imem_req_valid}, 32'h0);
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", bus.imem_req_addr, model_pc);
            pend_q.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
            exp_q.push_back({bus.imem_req_addr, data_of(bus.imem_req_addr)});
            hs_q.push_back(bus.imem_req_addr);
            model_pc = model_pc + 32'd4;
        end
        if (bus.redirect_valid) begin
            exp_q.delete();
            model_pc = {bus.redirect_pc[31:2], 2'b00};
        end else if (bus.if_valid && bus.if_ready) begin
            check("sb_nonempty", {31'h0, exp_q.size() != 0}, 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("if_pc", bus.if_pc, e[63:32]);
                check("if_inst", bus.if_inst, e[31:0]);
                deliv_q.push_back(bus.if_pc);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.if_ready        = 1'b0;
        pend_q.delete();
        exp_q.delete();
        deliv_q.delete();
        hs_q.delete();
        model_pc = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        int n;
        // Reset state
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.if_ready        = 1'b0;
        model_pc            = 32'h0;
        #12;
        check("rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
        check("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        check("rst_fetch_pc", bus.fetch_pc, 32'h0);
        check("rst_if_pc", bus.if_pc, 32'h0);
        check("rst_if_inst", bus.if_inst, 32'h0);

        // Streaming with ready memory and ready decode
        do_reset();
        bus.if_ready = 1'b1;
        lat = 1;
        #1;
        check("first_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        check("first_req_addr", bus.imem_req_addr, 32'h0);
        repeat (12) step();
        check("stream_cnt", {31'h0, deliv_q.size() >= 6}, 32'h1);
        if (deliv_q.size() >= 3) begin
            check("stream_pc0", deliv_q[0], 32'h0);
            check("stream_pc1", deliv_q[1], 32'h4);
            check("stream_pc2", deliv_q[2], 32'h8);
        end

        // Decode stalled: credits cap at two requests
        do_reset();
        bus.if_ready = 1'b0;
        repeat (10) begin
            step();
            if (bus.if_valid) check("stall_hold_pc", bus.if_pc, 32'h0);
        end
        check("stall_req_cnt", hs_q.size(), 32'd2);
        #1;
        check("stall_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
        bus.if_ready = 1'b1;
        repeat (6) step();
        check("stall_drain_cnt", {31'h0, deliv_q.size() >= 2}, 32'h1);

        // Redirect with two 3-cycle requests outstanding
        do_reset();
        bus.if_ready = 1'b1;
        bus.imem_req_ready = 1'b0;
        redirect_to(32'h10);
        bus.imem_req_ready = 1'b1;
        lat = 3;
        n = 0;
        while (pend_q.size() < 2 && n < 10) begin
            step();
            n++;
        end
        check("wait_two_out", pend_q.size(), 32'd2);
        check("out_addr0", pend_q[0].addr, 32'h10);
        redirect_to(32'h200);
        deliv_q.delete();
        n = 0;
        while (deliv_q.size() == 0 && n < 20) begin
            step();
            n++;
        end
        check("redir_first_pc", (deliv_q.size() > 0) ? deliv_q[0] : 32'hFFFF_FFFF, 32'h200);

        // Redirect to unaligned target, request issued the very next cycle
        bus.imem_req_ready = 1'b0;
        lat = 1;
        redirect_to(32'h103);
        bus.imem_req_ready = 1'b1;
        #1;
        check("align_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        check("align_req_addr", bus.imem_req_addr, 32'h100);
        deliv_q.delete();
        hs_q.delete();
        repeat (8) step();
        check("align_hs1", (hs_q.size() > 1) ? hs_q[1] : 32'hFFFF_FFFF, 32'h104);
        check("align_if_pc", (deliv_q.size() > 0) ? deliv_q[0] : 32'hFFFF_FFFF, 32'h100);

        // PC wrap at the top of the address space
        bus.imem_req_ready = 1'b0;
        redirect_to(32'hFFFF_FFFC);
        bus.imem_req_ready = 1'b1;
        hs_q.delete();
        repeat (2) step();
        check("wrap_hs0", (hs_q.size() > 0) ? hs_q[0] : 32'h1, 32'hFFFF_FFFC);
        check("wrap_hs1", (hs_q.size() > 1) ? hs_q[1] : 32'h1, 32'h0);
        repeat (6) step();

        // Asynchronous reset with a buffered instruction and one outstanding request
        do_reset();
        bus.if_ready = 1'b0;
        lat = 2;
        n = 0;
        while (!(bus.if_valid === 1'b1 && pend_q.size() == 1) && n < 10) begin
            step();
            n++;
        end
        check("pre_rst_valid", {31'h0, bus.if_valid}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("async_if_valid", {31'h0, bus.if_valid}, 32'h0);
        check("async_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        do_reset();
        #1;
        check("post_rst_valid", {31'h0, bus.if_valid}, 32'h0);
        bus.if_ready = 1'b1;
        lat = 1;
        repeat (8) step();
        check("post_rst_pc", (deliv_q.size() > 0) ? deliv_q[0] : 32'hFFFF_FFFF, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
